// File: rtl/uart_tx.sv
// UART byte transmitter with a one-byte holding register.
// Frames are: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// When a byte is waiting at the end of the last stop period, the next start bit follows
// with no idle time between frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_done,
  output logic       tx_overrun,
  output logic       busy,
  output logic       tx
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   baud_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic            stop_cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [7:0]      hold_q;
  logic            hold_full_q;
  logic            tx_q;
  logic            tx_done_q;
  logic            tx_overrun_q;
  logic            busy_q;

  logic            bit_end;
  logic            frame_end;
  logic            load;
  logic            accept;
  logic            hold_full_d;
  logic            idle_d;
  logic            busy_d;

  // Last clock of the current bit period.
  assign bit_end     = (baud_cnt_q == BAUD_LAST);
  // Last clock of the final stop bit: the line is free on the next edge.
  assign frame_end   = (state_q == S_STOP) && bit_end && (stop_cnt_q == STOP_LAST);
  // Move the held byte into the shifter whenever the line is (or is about to be) free.
  assign load        = hold_full_q && ((state_q == S_IDLE) || frame_end);
  // A write is taken if the holding register is empty or being drained this cycle.
  assign accept      = tx_wr && (!hold_full_q || load);
  assign hold_full_d = accept || (hold_full_q && !load);
  assign idle_d      = !load && ((state_q == S_IDLE) || frame_end);
  assign busy_d      = !idle_d || hold_full_d;

  // Holding register: captures tx_data on an accepted write, empties on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q <= tx_data;
      end
      hold_full_q <= hold_full_d;
    end
  end

  // Frame sequencer: bit timing, shifter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      tx_done_q    <= 1'b0;
      tx_overrun_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      tx_done_q    <= load;
      tx_overrun_q <= tx_wr && !accept;
      busy_q       <= busy_d;
      if (load) begin
        // Start bit goes out on this edge; parity is fixed from the loaded byte.
        shift_q    <= hold_q;
        par_q      <= (PARITY == 1) ? ~^hold_q : ^hold_q;
        state_q    <= S_START;
        baud_cnt_q <= '0;
        tx_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            tx_q <= 1'b1;
          end
          S_START: begin
            if (bit_end) begin
              baud_cnt_q <= '0;
              bit_cnt_q  <= '0;
              tx_q       <= shift_q[0];
              shift_q    <= {1'b0, shift_q[7:1]};
              state_q    <= S_DATA;
            end else begin
              baud_cnt_q <= baud_cnt_q + BW'(1);
            end
          end
          S_DATA: begin
            if (bit_end) begin
              baud_cnt_q <= '0;
              if (bit_cnt_q == 3'd7) begin
                if (PARITY != 0) begin
                  state_q <= S_PARITY;
                  tx_q    <= par_q;
                end else begin
                  state_q    <= S_STOP;
                  stop_cnt_q <= 1'b0;
                  tx_q       <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                tx_q      <= shift_q[0];
                shift_q   <= {1'b0, shift_q[7:1]};
              end
            end else begin
              baud_cnt_q <= baud_cnt_q + BW'(1);
            end
          end
          S_PARITY: begin
            if (bit_end) begin
              baud_cnt_q <= '0;
              state_q    <= S_STOP;
              stop_cnt_q <= 1'b0;
              tx_q       <= 1'b1;
            end else begin
              baud_cnt_q <= baud_cnt_q + BW'(1);
            end
          end
          S_STOP: begin
            if (bit_end) begin
              baud_cnt_q <= '0;
              if (stop_cnt_q == STOP_LAST) begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
              end else begin
                stop_cnt_q <= 1'b1;
              end
            end else begin
              baud_cnt_q <= baud_cnt_q + BW'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign tx_done    = tx_done_q;
  assign tx_overrun = tx_overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three differently configured transmitters share one stimulus stream.
// A timeline model predicts when each byte starts and which writes overrun; monitors
// decode the serial lines and the pulse outputs and check them against queued expectations.
module tb_uart_tx;

  localparam int NDUT = 3;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  logic            clk;
  logic            rst;
  logic [7:0]      tx_data;
  logic            tx_wr;
  logic [NDUT-1:0] tx_done_w;
  logic [NDUT-1:0] tx_overrun_w;
  logic [NDUT-1:0] busy_w;
  logic [NDUT-1:0] tx_w;

  int edge_n = 0;
  int epoch  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit         hold_v   [NDUT];
  logic [7:0] hold_b   [NDUT];
  int         free_at  [NDUT];
  bit         exp_busy [NDUT];

  frame_t frame_q [NDUT][$];
  int     done_q  [NDUT][$];
  int     ovr_q   [NDUT][$];

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_done(tx_done_w[0]), .tx_overrun(tx_overrun_w[0]), .busy(busy_w[0]), .tx(tx_w[0])
  );
  uart_tx #(.CLKS_PER_BIT(5), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_done(tx_done_w[1]), .tx_overrun(tx_overrun_w[1]), .busy(busy_w[1]), .tx(tx_w[1])
  );
  uart_tx #(.CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_done(tx_done_w[2]), .tx_overrun(tx_overrun_w[2]), .busy(busy_w[2]), .tx(tx_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int cpb(input int d);
    case (d)
      0: return 4;
      1: return 5;
      default: return 3;
    endcase
  endfunction

  function automatic int par_mode(input int d);
    case (d)
      0: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int stop_bits(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int nbits(input int d);
    return 9 + ((par_mode(d) != 0) ? 1 : 0) + stop_bits(d);
  endfunction

  // Expected line levels, bit 0 = start bit; unused upper positions stay at mark.
  function automatic logic [11:0] frame_bits(input int d, input logic [7:0] b);
    logic [11:0] bits;
    int ones;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    ones = $countones(b);
    if (par_mode(d) == 2) bits[9] = ((ones % 2) == 1);
    if (par_mode(d) == 1) bits[9] = ((ones % 2) == 0);
    return bits;
  endfunction

  task automatic chk(input bit ok, input string msg);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", msg);
    end
  endtask

  // Timeline model for one clock edge k: a waiting byte starts once the line is free,
  // then a write is taken only if the holding slot is empty.
  task automatic model_edge(input int d, input int k, input bit wr, input logic [7:0] data);
    frame_t f;
    if (hold_v[d] && k >= free_at[d]) begin
      f.data  = hold_b[d];
      f.start = k;
      frame_q[d].push_back(f);
      done_q[d].push_back(k);
      free_at[d] = k + nbits(d) * cpb(d);
      hold_v[d]  = 1'b0;
    end
    if (wr) begin
      if (!hold_v[d]) begin
        hold_v[d] = 1'b1;
        hold_b[d] = data;
      end else begin
        ovr_q[d].push_back(k);
      end
    end
    exp_busy[d] = hold_v[d] || (k < free_at[d]);
  endtask

  task automatic step(input bit wr, input logic [7:0] data);
    int k;
    tx_wr   = wr;
    tx_data = data;
    k = edge_n + 1;
    for (int d = 0; d < NDUT; d++) model_edge(d, k, wr, data);
    @(negedge clk);
    tx_wr = 1'b0;
    for (int d = 0; d < NDUT; d++)
      chk(busy_w[d] === exp_busy[d],
          $sformatf("busy dut%0d edge %0d: got %b, expected %b", d, k, busy_w[d], exp_busy[d]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    tx_wr = 1'b0;
    rst   = 1'b1;
    epoch++;
    for (int d = 0; d < NDUT; d++) begin
      hold_v[d]   = 1'b0;
      free_at[d]  = 0;
      exp_busy[d] = 1'b0;
    end
    repeat (n) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk(tx_w[d] === 1'b1, $sformatf("reset tx dut%0d: got %b, expected 1", d, tx_w[d]));
      chk(busy_w[d] === 1'b0, $sformatf("reset busy dut%0d: got %b, expected 0", d, busy_w[d]));
      chk(tx_done_w[d] === 1'b0 && tx_overrun_w[d] === 1'b0,
          $sformatf("reset pulses dut%0d: got done=%b ovr=%b, expected 0/0",
                    d, tx_done_w[d], tx_overrun_w[d]));
    end
  endtask

  // Serial-line monitor: decodes each frame at mid-bit and checks it against the queue.
  task automatic mon_frame(input int d);
    int s, c, n, my_ep;
    bit ab;
    logic [11:0] rx, ex;
    frame_t f;
    forever begin
      @(negedge clk);
      if (tx_w[d] === 1'b0) begin
        s = edge_n; my_ep = epoch; c = cpb(d); n = nbits(d); rx = '1; ab = 1'b0;
        for (int i = 0; i < n; i++) begin
          while (!ab && edge_n < s + i * c + c / 2) begin
            @(negedge clk);
            if (epoch != my_ep) ab = 1'b1;
          end
          if (ab) break;
          rx[i] = tx_w[d];
        end
        if (ab) begin
          if (frame_q[d].size() > 0) void'(frame_q[d].pop_front());
        end else if (frame_q[d].size() == 0) begin
          chk(1'b0, $sformatf("frame dut%0d: unexpected frame bits %b at edge %0d, none expected",
                              d, rx, s));
        end else begin
          f  = frame_q[d].pop_front();
          ex = frame_bits(d, f.data);
          chk(rx === ex && s == f.start,
              $sformatf("frame dut%0d byte %02h: got bits %b start edge %0d, expected bits %b start edge %0d",
                        d, f.data, rx, s, ex, f.start));
        end
      end
    end
  endtask

  // Pulse monitor: every tx_done / tx_overrun must match a predicted edge.
  task automatic mon_pulse(input int d);
    int e;
    forever begin
      @(negedge clk);
      if (tx_done_w[d] === 1'b1) begin
        if (done_q[d].size() == 0) begin
          chk(1'b0, $sformatf("tx_done dut%0d: pulse at edge %0d, none expected", d, edge_n));
        end else begin
          e = done_q[d].pop_front();
          chk(e == edge_n, $sformatf("tx_done dut%0d: got edge %0d, expected edge %0d", d, edge_n, e));
        end
      end
      if (tx_overrun_w[d] === 1'b1) begin
        if (ovr_q[d].size() == 0) begin
          chk(1'b0, $sformatf("tx_overrun dut%0d: pulse at edge %0d, none expected", d, edge_n));
        end else begin
          e = ovr_q[d].pop_front();
          chk(e == edge_n, $sformatf("tx_overrun dut%0d: got edge %0d, expected edge %0d", d, edge_n, e));
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    fork
      mon_frame(0);
      mon_frame(1);
      mon_frame(2);
      mon_pulse(0);
      mon_pulse(1);
      mon_pulse(2);
    join_none

    do_reset(3);

    // single byte
    step(1'b1, 8'hA5);
    idle(70);

    // second byte written as the first one's tx_done appears: gapless pair
    step(1'b1, 8'h01);
    step(1'b0, 8'h00);
    step(1'b1, 8'h02);
    idle(130);

    // three consecutive writes: third one overruns
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    idle(140);

    // parity pattern and back-to-back extremes
    step(1'b1, 8'h07);
    idle(70);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h00);
    idle(140);

    // reset in the middle of a frame, then a clean byte
    step(1'b1, 8'h55);
    idle(17);
    do_reset(1);
    idle(10);
    step(1'b1, 8'h3C);
    idle(70);

    // random traffic: dense then sparse writes
    for (int i = 0; i < 300; i++) step($urandom_range(0, 7) == 0, 8'($urandom));
    for (int i = 0; i < 300; i++) step($urandom_range(0, 39) == 0, 8'($urandom));
    idle(150);

    for (int d = 0; d < NDUT; d++) begin
      chk(frame_q[d].size() == 0,
          $sformatf("drain frames dut%0d: got %0d pending, expected 0", d, frame_q[d].size()));
      chk(done_q[d].size() == 0,
          $sformatf("drain tx_done dut%0d: got %0d pending, expected 0", d, done_q[d].size()));
      chk(ovr_q[d].size() == 0,
          $sformatf("drain tx_overrun dut%0d: got %0d pending, expected 0", d, ovr_q[d].size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
